mailbox_port_arb: RTL and testbench
===================================

MAILBOX_PORT_ARB -- requirements
Module: mailbox_port_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, the number of requesters sharing one mailbox side port (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 255, the maximum number of cycles to wait for m_ready (1..255).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port s_req, input, NUM_REQ, per-requester request level, held until s_ready or s_err.
REQ-006 SHALL have port s_write, input, NUM_REQ, per-requester direction: 1 = write, 0 = read.
REQ-007 SHALL have port s_addr, input, NUM_REQ*6, per-requester byte address, with requester i at bits [6i+5:6i].
REQ-008 SHALL have port s_wdata, input, NUM_REQ*32, per-requester write data, with requester i at bits [32i+31:32i].
REQ-009 SHALL have port s_ready, output, NUM_REQ, a one-cycle completion pulse to the granted requester.
REQ-010 SHALL have port s_err, output, NUM_REQ, a one-cycle timeout-abort pulse to the granted requester.
REQ-011 SHALL have port s_rdata, output, 32, the read data, valid in the cycle s_ready pulses for a read.
REQ-012 SHALL have port m_write_out, output, 1, the write strobe level to the mailbox side port.
REQ-013 SHALL have port m_read_out, output, 1, the read strobe level to the mailbox side port.
REQ-014 SHALL have port m_addr, output, 6, the address to the mailbox side port.
REQ-015 SHALL have port m_wdata, output, 32, the write data to the mailbox side port.
REQ-016 SHALL have port m_ready, input, 1, the mailbox completion for read or write.
REQ-017 SHALL have port m_rdata, input, 32, the mailbox read data.
REQ-018 SHALL have port grant_id, output, 3, the index of the current or most recent grant.
REQ-019 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-020 SHALL use the FSM states IDLE, ISSUE, WAIT, RESP.
REQ-021 IDLE: if any s_req bit is high, SHALL select a winner by round-robin starting at (last_grant+1) mod NUM_REQ, register the winner's write/addr/wdata, set grant_id, and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-022 ISSUE: SHALL assert m_write_out (write) or m_read_out (read) with the registered m_addr/m_wdata, clear the timeout counter, and go to WAIT next cycle.
REQ-023 WAIT: SHALL hold the strobe, address and data stable and increment the timeout counter each cycle that m_ready is low.
REQ-024 WAIT with m_ready high SHALL capture m_rdata into s_rdata (reads only; writes leave s_rdata unchanged), drop the strobe, and go to RESP.
REQ-025 WAIT with the counter equal to TIMEOUT and m_ready low SHALL drop the strobe, flag an error, and go to RESP.
REQ-026 RESP: SHALL pulse s_ready[grant_id], or s_err[grant_id] if the error flag is set, for exactly one cycle, update last_grant to grant_id, and return to IDLE.
REQ-027 Strobes SHALL be low for at least 2 cycles (RESP, IDLE) between consecutive mailbox transactions.
REQ-028 s_ready and s_err SHALL never both pulse, and SHALL never pulse to more than one requester at a time.
REQ-029 Minimum latency SHALL be 4 cycles from s_req to the s_ready pulse when m_ready returns 1 cycle after the strobe.
REQ-030 s_req changes of non-granted requesters SHALL not affect an in-flight transaction; deassertion of the granted s_req mid-transaction SHALL be ignored and the transaction completed.
REQ-031 m_ready seen in ISSUE, IDLE or RESP SHALL be ignored.
REQ-032 With all NUM_REQ requesters asserted continuously, each SHALL be granted exactly once per NUM_REQ transactions.
REQ-033 The timeout counter SHALL be 8 bits and saturate at TIMEOUT, never wrapping.

Reset
REQ-034 While reset is high, outputs SHALL be forced to: FSM=IDLE, m_write_out=0, m_read_out=0, m_addr=0, m_wdata=0, s_ready=0, s_err=0, s_rdata=0, busy=0, grant_id=0, error flag=0, counter=0, last_grant=NUM_REQ-1 (so requester 0 is granted first).
REQ-035 Reset asserted mid-transaction SHALL abort it in the next cycle without any s_ready/s_err pulse, and strobes SHALL be low from the following cycle.

Verification
REQ-036 Single read: s_req=0001, s_write=0, s_addr[0]=0x20, m_ready high 1 cycle after m_read_out with m_rdata=0xCAFE0001 -> m_addr=0x20, s_ready=0001 for 1 cycle, s_rdata=0xCAFE0001, 4-cycle latency.
REQ-037 Contention: s_req=1111 held, all writes -> grant order 0,1,2,3,0; each m_wdata matches its requester; strobes low for 2 cycles between transactions.
REQ-038 Timeout: TIMEOUT=4, read request, m_ready held low -> strobe high for 5 cycles, then s_err pulses once, s_ready stays 0, and the next request is served normally.
REQ-039 Reset mid-WAIT: reset asserted for 1 cycle during WAIT -> no s_ready/s_err pulse, all outputs at reset values, and the next grant goes to requester 0.
REQ-040 Requester drop and late m_ready: granted requester 2 deasserts s_req in WAIT; m_ready pulses during RESP -> the transaction completes with s_ready=0100, and the stray m_ready produces no extra pulse.
REQ-041 Fairness: requesters 1 and 3 held continuously over 8 transactions -> grants alternate 1,3,1,3..., with a 4-of-8 split.

Source files
------------

// File: rtl/mailbox_port_arb.sv
// Round-robin arbiter that shares one mailbox side port among NUM_REQ requesters.
// Each grant issues one strobed access, waits a bounded time for m_ready, then responds.
module mailbox_port_arb #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    s_req,
  input  logic [NUM_REQ-1:0]    s_write,
  input  logic [NUM_REQ*6-1:0]  s_addr,
  input  logic [NUM_REQ*32-1:0] s_wdata,
  output logic [NUM_REQ-1:0]    s_ready,
  output logic [NUM_REQ-1:0]    s_err,
  output logic [31:0]           s_rdata,
  output logic                  m_write_out,
  output logic                  m_read_out,
  output logic [5:0]            m_addr,
  output logic [31:0]           m_wdata,
  input  logic                  m_ready,
  input  logic [31:0]           m_rdata,
  output logic [2:0]            grant_id,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [7:0]         TIMEOUT_C  = 8'(TIMEOUT);
  localparam logic [2:0]         LAST_RST_C = 3'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_C      = NUM_REQ'(1);
  localparam logic [NUM_REQ-1:0] ZERO_C     = {NUM_REQ{1'b0}};

  state_t               state_r;
  logic [2:0]           last_grant_r;
  logic [2:0]           grant_id_r;
  logic [7:0]           cnt_r;
  logic [NUM_REQ-1:0]   s_ready_r;
  logic [NUM_REQ-1:0]   s_err_r;
  logic [31:0]          s_rdata_r;
  logic                 m_write_r;
  logic                 m_read_r;
  logic [5:0]           m_addr_r;
  logic [31:0]          m_wdata_r;
  logic                 busy_r;

  logic [2:0]           win_s;
  logic                 win_write_s;
  logic [5:0]           win_addr_s;
  logic [31:0]          win_wdata_s;
  logic [7:0]           cnt_inc_s;

  // First requesting index found scanning upward from the one after the last grant.
  function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] req, input logic [2:0] last);
    logic [2:0] pick;
    logic       found;
    logic       hit;
    int         cand;
    pick  = 3'd0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand  = (int'(last) + i) % NUM_REQ;
      hit   = 1'(req >> cand);
      pick  = (!found && hit) ? 3'(cand) : pick;
      found = found | hit;
    end
    return pick;
  endfunction

  // Winner selection and saturating timeout increment.
  always_comb begin
    win_s       = rr_pick(s_req, last_grant_r);
    win_write_s = 1'(s_write >> win_s);
    win_addr_s  = 6'(s_addr >> (6 * int'(win_s)));
    win_wdata_s = 32'(s_wdata >> (32 * int'(win_s)));
    if (cnt_r == TIMEOUT_C) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + 8'd1;
    end
  end

  // Transaction FSM; every output is a flop updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      last_grant_r <= LAST_RST_C;
      grant_id_r   <= 3'd0;
      cnt_r        <= 8'd0;
      s_ready_r    <= ZERO_C;
      s_err_r      <= ZERO_C;
      s_rdata_r    <= 32'd0;
      m_write_r    <= 1'b0;
      m_read_r     <= 1'b0;
      m_addr_r     <= 6'd0;
      m_wdata_r    <= 32'd0;
      busy_r       <= 1'b0;
    end else begin
      s_ready_r <= ZERO_C;
      s_err_r   <= ZERO_C;
      case (state_r)
        IDLE: begin
          if (|s_req) begin
            grant_id_r <= win_s;
            m_write_r  <= win_write_s;
            m_read_r   <= ~win_write_s;
            m_addr_r   <= win_addr_s;
            m_wdata_r  <= win_wdata_s;
            busy_r     <= 1'b1;
            state_r    <= ISSUE;
          end else begin
            busy_r     <= 1'b0;
            state_r    <= IDLE;
          end
        end
        ISSUE: begin
          cnt_r   <= 8'd0;
          state_r <= WAIT;
        end
        WAIT: begin
          if (m_ready) begin
            if (!m_write_r) begin
              s_rdata_r <= m_rdata;
            end else begin
              s_rdata_r <= s_rdata_r;
            end
            m_write_r <= 1'b0;
            m_read_r  <= 1'b0;
            s_ready_r <= ONE_C << grant_id_r;
            state_r   <= RESP;
          end else if (cnt_inc_s == TIMEOUT_C) begin
            // Give up: the pulse goes out on s_err instead of s_ready.
            cnt_r     <= cnt_inc_s;
            m_write_r <= 1'b0;
            m_read_r  <= 1'b0;
            s_err_r   <= ONE_C << grant_id_r;
            state_r   <= RESP;
          end else begin
            cnt_r     <= cnt_inc_s;
            state_r   <= WAIT;
          end
        end
        RESP: begin
          last_grant_r <= grant_id_r;
          busy_r       <= 1'b0;
          state_r      <= IDLE;
        end
        default: begin
          m_write_r <= 1'b0;
          m_read_r  <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign s_ready     = s_ready_r;
  assign s_err       = s_err_r;
  assign s_rdata     = s_rdata_r;
  assign m_write_out = m_write_r;
  assign m_read_out  = m_read_r;
  assign m_addr      = m_addr_r;
  assign m_wdata     = m_wdata_r;
  assign grant_id    = grant_id_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_mailbox_port_arb.sv
// Directed scoreboard bench: stimulus pushes expected mailbox accesses and responses,
// two monitors pop and compare whenever the DUT strobes the mailbox or pulses a requester.
module tb_mailbox_port_arb;

  logic         clk;
  logic         reset;
  logic [3:0]   s_req;
  logic [3:0]   s_write;
  logic [23:0]  s_addr;
  logic [127:0] s_wdata;
  logic [3:0]   s_ready;
  logic [3:0]   s_err;
  logic [31:0]  s_rdata;
  logic         m_write_out;
  logic         m_read_out;
  logic [5:0]   m_addr;
  logic [31:0]  m_wdata;
  logic         m_ready;
  logic [31:0]  m_rdata;
  logic [2:0]   grant_id;
  logic         busy;

  mailbox_port_arb #(.NUM_REQ(4), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .s_req(s_req), .s_write(s_write), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_ready(s_ready), .s_err(s_err), .s_rdata(s_rdata),
    .m_write_out(m_write_out), .m_read_out(m_read_out), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata),
    .grant_id(grant_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic wr; logic [5:0] addr; logic [31:0] wdata; logic [2:0] gid; } mbx_t;
  typedef struct { logic [3:0] ready; logic [3:0] err; logic chk_rd; logic [31:0] rdata; logic [2:0] gid; } rsp_t;

  mbx_t mbx_q[$];
  rsp_t rsp_q[$];
  int   total = 0;
  int   bad = 0;

  // responder and monitor controls
  int          resp_delay = 1;
  bit          resp_en = 1'b1;
  bit          stray_en = 1'b0;
  logic [31:0] rd_val = 32'd0;
  int          run_k = 0;
  int          exp_len = 0;
  bit          gap_exact = 1'b0;
  int          grant_cnt[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic void exp_mbx(input int id, input logic wr, input logic [5:0] a, input logic [31:0] wd);
    mbx_t m;
    m.wr = wr; m.addr = a; m.wdata = wd; m.gid = 3'(id);
    mbx_q.push_back(m);
  endfunction

  function automatic void exp_txn(input int id, input logic wr, input logic [5:0] a,
                                  input logic [31:0] wd, input logic tout, input logic [31:0] rd);
    rsp_t r;
    logic [3:0] oh;
    oh = 4'b0001 << id;
    exp_mbx(id, wr, a, wd);
    r.ready = tout ? 4'b0000 : oh;
    r.err = tout ? oh : 4'b0000;
    r.chk_rd = !wr && !tout;
    r.rdata = rd;
    r.gid = 3'(id);
    rsp_q.push_back(r);
  endfunction

  task automatic set_port(input int id, input logic wr, input logic [5:0] a, input logic [31:0] wd);
    s_write[id] = wr;
    s_addr[id*6 +: 6] = a;
    s_wdata[id*32 +: 32] = wd;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_vals(input string p);
    check({p, "_s_ready"}, s_ready, 4'b0);
    check({p, "_s_err"}, s_err, 4'b0);
    check({p, "_s_rdata"}, s_rdata, 32'd0);
    check({p, "_m_write_out"}, m_write_out, 1'b0);
    check({p, "_m_read_out"}, m_read_out, 1'b0);
    check({p, "_m_addr"}, m_addr, 6'd0);
    check({p, "_m_wdata"}, m_wdata, 32'd0);
    check({p, "_grant_id"}, grant_id, 3'd0);
    check({p, "_busy"}, busy, 1'b0);
  endtask

  // Requesters in mask raise s_req and each drops it after its own pulse.
  task automatic serve(input logic [3:0] mask);
    int cyc;
    cyc = 0;
    s_req = s_req | mask;
    while ((s_req & mask) != 4'b0 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      s_req = s_req & ~(s_ready | s_err);
    end
    check("serve_done", ((s_req & mask) == 4'b0), 1'b1);
    s_req = s_req & ~mask;
  endtask

  // Requesters in mask hold s_req for n completed transactions.
  task automatic run_held(input logic [3:0] mask, input int n);
    int cyc;
    int got;
    cyc = 0;
    got = 0;
    s_req = mask;
    while (got < n && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
      if ((s_ready | s_err) != 4'b0) begin
        got++;
        for (int i = 0; i < 4; i++) if (s_ready[i]) grant_cnt[i]++;
        if (got == 1) gap_exact = 1'b1;
      end
    end
    s_req = 4'b0;
    gap_exact = 1'b0;
    check("held_count", got, n);
  endtask

  // mailbox responder: m_ready pulse resp_delay cycles after the strobe rises
  initial begin
    m_ready = 1'b0;
    m_rdata = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (m_write_out || m_read_out) run_k++;
      else run_k = 0;
      m_rdata = rd_val;
      m_ready = 1'b0;
      if (resp_en && run_k == resp_delay + 1) m_ready = 1'b1;
      if (stray_en && s_ready != 4'b0) m_ready = 1'b1;
    end
  end

  // mailbox side monitor
  logic strobe_now;
  logic prev_strobe = 1'b0;
  bit   have_prev = 1'b0;
  int   gap = 0;
  int   run_len = 0;
  mbx_t me;
  always @(negedge clk) begin
    if (reset) begin
      prev_strobe = 1'b0; have_prev = 1'b0; gap = 0; run_len = 0;
    end else begin
      strobe_now = m_write_out | m_read_out;
      check("one_strobe", (m_write_out & m_read_out), 1'b0);
      if (strobe_now && !prev_strobe) begin
        if (have_prev) begin
          if (gap_exact) check("strobe_gap", gap, 2);
          else check("strobe_gap_min", (gap >= 2), 1'b1);
        end
        check("strobe_expected", (mbx_q.size() != 0), 1'b1);
        if (mbx_q.size() != 0) begin
          me = mbx_q.pop_front();
          check("m_write_out", m_write_out, me.wr);
          check("m_read_out", m_read_out, !me.wr);
          check("m_addr", m_addr, me.addr);
          if (me.wr) check("m_wdata", m_wdata, me.wdata);
          check("grant_id", grant_id, me.gid);
        end
        run_len = 0;
      end
      if (strobe_now) run_len++;
      else begin
        if (prev_strobe) begin
          if (exp_len > 0) check("strobe_len", run_len, exp_len);
          have_prev = 1'b1;
          gap = 0;
        end
        gap++;
      end
      prev_strobe = strobe_now;
    end
  end

  // requester side monitor
  rsp_t re;
  always @(negedge clk) begin
    if (!reset && (s_ready != 4'b0 || s_err != 4'b0)) begin
      check("pulse_expected", (rsp_q.size() != 0), 1'b1);
      if (rsp_q.size() != 0) begin
        re = rsp_q.pop_front();
        check("s_ready", s_ready, re.ready);
        check("s_err", s_err, re.err);
        check("rsp_grant_id", grant_id, re.gid);
        if (re.chk_rd) check("s_rdata", s_rdata, re.rdata);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int cyc;
    int lat;
    bit got;
    reset = 1'b1; s_req = 4'b0; s_write = 4'b0; s_addr = 24'd0; s_wdata = 128'd0;
    for (int i = 0; i < 4; i++) grant_cnt[i] = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_vals("init");
    idle(1);

    // contention: all four writing, order 0,1,2,3,0
    set_port(0, 1'b1, 6'h05, 32'h1000_0000);
    set_port(1, 1'b1, 6'h12, 32'h2000_0001);
    set_port(2, 1'b1, 6'h21, 32'h3000_0002);
    set_port(3, 1'b1, 6'h3C, 32'h4000_0003);
    exp_txn(0, 1'b1, 6'h05, 32'h1000_0000, 1'b0, 32'd0);
    exp_txn(1, 1'b1, 6'h12, 32'h2000_0001, 1'b0, 32'd0);
    exp_txn(2, 1'b1, 6'h21, 32'h3000_0002, 1'b0, 32'd0);
    exp_txn(3, 1'b1, 6'h3C, 32'h4000_0003, 1'b0, 32'd0);
    exp_txn(0, 1'b1, 6'h05, 32'h1000_0000, 1'b0, 32'd0);
    run_held(4'b1111, 5);
    idle(2);

    // fairness: 1 and 3 held, alternate over 8 reads
    for (int i = 0; i < 4; i++) grant_cnt[i] = 0;
    rd_val = 32'h5A5A_A5A5;
    set_port(1, 1'b0, 6'h15, 32'd0);
    set_port(3, 1'b0, 6'h33, 32'd0);
    for (int t = 0; t < 4; t++) begin
      exp_txn(1, 1'b0, 6'h15, 32'd0, 1'b0, 32'h5A5A_A5A5);
      exp_txn(3, 1'b0, 6'h33, 32'd0, 1'b0, 32'h5A5A_A5A5);
    end
    run_held(4'b1010, 8);
    check("fair_cnt1", grant_cnt[1], 4);
    check("fair_cnt3", grant_cnt[3], 4);
    idle(2);

    // single read with minimum latency
    rd_val = 32'hCAFE_0001;
    set_port(0, 1'b0, 6'h20, 32'd0);
    exp_txn(0, 1'b0, 6'h20, 32'd0, 1'b0, 32'hCAFE_0001);
    exp_len = 2;
    s_req = 4'b0001;
    lat = 1;
    while (s_ready[0] == 1'b0 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    s_req = 4'b0000;
    check("latency", lat, 4);
    idle(2);

    // timeout with TIMEOUT=4, then a normal read
    resp_en = 1'b0;
    exp_len = 5;
    set_port(1, 1'b0, 6'h11, 32'd0);
    exp_txn(1, 1'b0, 6'h11, 32'd0, 1'b1, 32'd0);
    serve(4'b0010);
    idle(2);
    resp_en = 1'b1;
    exp_len = 2;
    rd_val = 32'h1234_5678;
    exp_txn(1, 1'b0, 6'h11, 32'd0, 1'b0, 32'h1234_5678);
    serve(4'b0010);
    idle(2);

    // reset during WAIT, then 0 must win over 2
    resp_en = 1'b0;
    exp_len = 0;
    set_port(3, 1'b1, 6'h3F, 32'hDEAD_BEEF);
    exp_mbx(3, 1'b1, 6'h3F, 32'hDEAD_BEEF);
    s_req = 4'b1000;
    cyc = 0;
    while (!m_write_out && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("e_strobe_up", m_write_out, 1'b1);
    idle(2);
    check("e_busy", busy, 1'b1);
    reset = 1'b1;
    s_req = 4'b0000;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_vals("midwait");
    resp_en = 1'b1;
    exp_len = 2;
    rd_val = 32'h0BAD_F00D;
    set_port(0, 1'b0, 6'h01, 32'd0);
    set_port(2, 1'b1, 6'h22, 32'h2222_0002);
    exp_txn(0, 1'b0, 6'h01, 32'd0, 1'b0, 32'h0BAD_F00D);
    exp_txn(2, 1'b1, 6'h22, 32'h2222_0002, 1'b0, 32'd0);
    serve(4'b0101);
    idle(2);

    // requester 2 drops mid-WAIT, stray m_ready during RESP
    resp_delay = 3;
    stray_en = 1'b1;
    exp_len = 4;
    set_port(2, 1'b1, 6'h2A, 32'hC0DE_0002);
    exp_txn(2, 1'b1, 6'h2A, 32'hC0DE_0002, 1'b0, 32'd0);
    s_req = 4'b0100;
    cyc = 0;
    while (!m_write_out && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    idle(2);
    s_req = 4'b0000;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
      if (s_ready[2]) got = 1'b1;
    end
    check("drop_completed", got, 1'b1);
    idle(6);
    stray_en = 1'b0;
    resp_delay = 1;
    exp_len = 0;

    idle(4);
    check("mbx_q_empty", mbx_q.size(), 0);
    check("rsp_q_empty", rsp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
